cmplx_div_sched: RTL and testbench

//  Round-robin scheduler that shares one cmplxDiv complex-divider instance among N requesters.

---
 rtl/cmplx_div_sched.sv | 187 ++++++++++++++++++
 tb/tb_cmplx_div_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : cmplx_div_sched
// Description : Round-robin scheduler sharing one pipelined complex divider
//               among N requesters. Issues at most one division per cycle,
//               tracks each in-flight op by requester ID, flags divide-by-zero
//               and buffers results in a response FIFO with valid/ready flow
//               control. Outstanding work is bounded by RSP_DEPTH credits.
// Revision    : 1.0 - initial release
// ============================================================================
module cmplx_div_sched #(
    parameter int N         = 4,
    parameter int ID_W      = 2,
    parameter int DIV_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*64-1:0]   req_a,
    input  logic [N*64-1:0]   req_b,
    output logic [63:0]       div_a,
    output logic [63:0]       div_b,
    input  logic [63:0]       div_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [63:0]       rsp_data,
    output logic              rsp_dz,
    output logic              busy
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int ENT_W = ID_W + 1 + 64;

    localparam logic [63:0]      DZ_DIVISOR = 64'h00000001_00000000;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N - 1);

    // Arbitration and issue
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  idx;
    logic             any_valid;
    logic             issue_ok;
    logic             issue;
    logic [63:0]      sel_a;
    logic [63:0]      sel_b;
    logic             sel_dz;

    // Divider operand registers
    logic [63:0]      div_a_q;
    logic [63:0]      div_b_q;

    // Tag pipeline, stage DIV_LAT lines up with div_out
    logic [DIV_LAT:0]           tag_v_q;
    logic [DIV_LAT:0][ID_W-1:0] tag_id_q;
    logic [DIV_LAT:0]           tag_dz_q;

    // Response FIFO and credit tracking
    logic [ENT_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] push_ent;
    logic [ENT_W-1:0] head;

    function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Rotating priority search: first valid requester starting at ptr_q
    always_comb begin
        grant     = ptr_q;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N);
            if (!any_valid && req_valid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

    // A pop in this cycle frees a credit immediately so a full scheduler keeps streaming
    assign pop       = rsp_valid & rsp_ready;
    assign issue_ok  = !reset && ((out_q != FULL_CNT) || pop);
    assign issue     = any_valid & issue_ok;
    assign req_ready = issue ? (N'(1) << grant) : '0;

    assign sel_a  = req_a[64*grant +: 64];
    assign sel_b  = req_b[64*grant +: 64];
    assign sel_dz = (sel_b == 64'h0);

    assign push     = tag_v_q[DIV_LAT];
    assign push_ent = {tag_id_q[DIV_LAT], tag_dz_q[DIV_LAT],
                       tag_dz_q[DIV_LAT] ? 64'h0 : div_out};

    // Next-state for pointer, FIFO indices, occupancy and outstanding count
    always_comb begin
        ptr_d = ptr_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (issue) begin
            ptr_d = (grant == LAST_ID) ? '0 : grant + 1'b1;
        end
        if (push) begin
            wr_d = next_slot(wr_q);
        end
        if (pop) begin
            rd_d = next_slot(rd_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({issue, pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    // Control state, operand registers and tag pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            div_a_q  <= '0;
            div_b_q  <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            tag_dz_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            tag_v_q  <= {tag_v_q[DIV_LAT-1:0], issue};
            tag_id_q <= {tag_id_q[DIV_LAT-1:0], grant};
            tag_dz_q <= {tag_dz_q[DIV_LAT-1:0], issue & sel_dz};
            if (issue) begin
                div_a_q <= sel_a;
                div_b_q <= sel_dz ? DZ_DIVISOR : sel_b;
            end
        end
    end

    // FIFO storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q] <= push_ent;
        end
    end

    // Credits must keep the FIFO from ever being written while full without a pop
    always_ff @(posedge clock) begin
        if (!reset && push && !pop) begin
            assert (cnt_q != FULL_CNT);
        end
    end

    assign head      = mem_q[rd_q];
    assign rsp_valid = (cnt_q != '0);
    assign rsp_id    = rsp_valid ? head[ENT_W-1 -: ID_W] : '0;
    assign rsp_dz    = rsp_valid & head[64];
    assign rsp_data  = rsp_valid ? head[63:0] : 64'h0;
    assign busy      = (|tag_v_q) | rsp_valid;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule
`default_nettype wire

// File: tb/tb_cmplx_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmplx_div_sched
// Description : Scoreboard bench for cmplx_div_sched with a behavioural
//               complex-divider stand-in and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmplx_div_sched;

    localparam int N         = 4;
    localparam int ID_W      = 2;
    localparam int DIV_LAT   = 2;
    localparam int RSP_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*64-1:0]   req_a;
    logic [N*64-1:0]   req_b;
    logic [63:0]       div_a;
    logic [63:0]       div_b;
    logic [63:0]       div_out = 64'h0;
    logic [63:0]       div_s1  = 64'h0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [63:0]       rsp_data;
    logic              rsp_dz;
    logic              busy;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            dz;
        logic [63:0]     data;
        int              t_rdy;
    } exp_t;

    exp_t        q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          issue_cnt = 0;
    int          cyc       = 0;
    int          ptr_m     = 0;
    logic [63:0] last_a    = 64'h0;
    logic [63:0] last_b    = 64'h0;

    cmplx_div_sched #(
        .N(N), .ID_W(ID_W), .DIV_LAT(DIV_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_out(div_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Integer complex division (a+bi)/(c+di), truncating toward zero
    function automatic logic [63:0] cdiv(input logic [63:0] x, input logic [63:0] y);
        longint ar, ai, br, bi, den, qr, qi;
        ar  = longint'($signed(x[63:32]));
        ai  = longint'($signed(x[31:0]));
        br  = longint'($signed(y[63:32]));
        bi  = longint'($signed(y[31:0]));
        den = br * br + bi * bi;
        if (den == 0) return 64'h0;
        qr = (ar * br + ai * bi) / den;
        qi = (ai * br - ar * bi) / den;
        return {32'(qr), 32'(qi)};
    endfunction

    // Two-cycle divider stand-in driven by the scheduler
    always @(posedge clock) begin
        div_s1  <= cdiv(div_a, div_b);
        div_out <= div_s1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rnd_c();
        return 32'($urandom_range(2000)) - 32'd1000;
    endfunction

    function automatic logic [63:0] rnd_b();
        if ($urandom_range(7) == 0) return 64'h0;
        return {rnd_c(), rnd_c()};
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            req_a[64*i +: 64] = {rnd_c(), rnd_c()};
            req_b[64*i +: 64] = rnd_b();
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'(busy), 64'h0);
    endtask

    // Issue tracker: predicts grants from the rotating pointer and credits, records expectations
    always @(negedge clock) begin
        logic [ID_W-1:0] g;
        logic [ID_W-1:0] cand;
        logic            found;
        logic            pop_m;
        logic            allowed;
        logic [N-1:0]    exp_rdy;
        logic [63:0]     b;
        exp_t            e;
        if (reset) begin
            chk("ready_in_reset", 64'(req_ready), 64'h0);
            q.delete();
            ptr_m  = 0;
            last_a = 64'h0;
            last_b = 64'h0;
        end else begin
            chk("div_a", div_a, last_a);
            chk("div_b", div_b, last_b);
            pop_m   = (q.size() > 0) && (q[0].t_rdy <= cyc) && rsp_ready;
            allowed = (q.size() < RSP_DEPTH) || pop_m;
            found   = 1'b0;
            g       = '0;
            for (int k = 0; k < N; k++) begin
                cand = ID_W'((ptr_m + k) % N);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    g     = cand;
                end
            end
            exp_rdy = (found && allowed) ? (N'(1) << g) : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (found && allowed) begin
                b       = req_b[64*g +: 64];
                e.id    = g;
                e.dz    = (b == 64'h0);
                e.data  = e.dz ? 64'h0 : cdiv(req_a[64*g +: 64], b);
                e.t_rdy = cyc + DIV_LAT + 2;
                q.push_back(e);
                ptr_m  = (int'(g) + 1) % N;
                last_a = req_a[64*g +: 64];
                last_b = e.dz ? 64'h00000001_00000000 : b;
                issue_cnt++;
            end
        end
    end

    // Response monitor: compares the FIFO head with the oldest expectation and retires it on pop
    always @(negedge clock) begin
        logic exp_v;
        logic exp_busy;
        #2;
        if (!reset) begin
            exp_v    = (q.size() > 0) && (q[0].t_rdy <= cyc);
            exp_busy = (q.size() > 0) && (q[0].t_rdy <= cyc + DIV_LAT + 1);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            chk("busy", 64'(busy), 64'(exp_busy));
            if (exp_v) begin
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_dz", 64'(rsp_dz), 64'(q[0].dz));
                chk("rsp_data", rsp_data, q[0].data);
                if (rsp_ready) void'(q.pop_front());
            end else begin
                chk("empty_head", {rsp_data[61:0], rsp_dz, 1'b0} | 64'(rsp_id), 64'h0);
            end
        end
    end

    initial begin
        int lat;
        int n0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_div_a", div_a, 64'h0);
        chk("rst_div_b", div_b, 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_rsp_dz", 64'(rsp_dz), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        tick();

        // Single op with a known quotient and latency
        req_a[63:0] = 64'h00000006_00000004;
        req_b[63:0] = 64'h00000001_00000001;
        req_valid   = 4'b0001;
        #1;
        chk("t1_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_data", rsp_data, 64'h00000005_FFFFFFFF);
        chk("t1_id", 64'(rsp_id), 64'h0);
        chk("t1_dz", 64'(rsp_dz), 64'h0);
        drain();

        // Fairness: everyone requesting, one grant per cycle
        rsp_ready = 1'b1;
        n0 = issue_cnt;
        for (int i = 0; i < 16; i++) begin
            req_valid = '1;
            randomize_ops();
            tick();
        end
        chk("t2_throughput", 64'(issue_cnt - n0), 64'd16);
        drain();

        // Backpressure: credits run out after RSP_DEPTH issues
        rsp_ready = 1'b0;
        n0 = issue_cnt;
        for (int i = 0; i < 10; i++) begin
            req_valid = '1;
            randomize_ops();
            tick();
        end
        chk("t3_issues_capped", 64'(issue_cnt - n0), 64'd4);
        chk("t3_ready_low", 64'(req_ready), 64'h0);
        rsp_ready = 1'b1;
        #1;
        chk("t3_pop_reissue", 64'($countones(req_ready)), 64'h1);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("t3_one_more_issue", 64'(issue_cnt - n0), 64'd5);
        chk("t3_ready_low_again", 64'(req_ready), 64'h0);
        drain();

        // Divide-by-zero from requester 2
        req_a[128 +: 64] = {rnd_c(), rnd_c()};
        req_b[128 +: 64] = 64'h0;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("t4_div_b", div_b, 64'h00000001_00000000);
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("t4_id", 64'(rsp_id), 64'h2);
        chk("t4_dz", 64'(rsp_dz), 64'h1);
        chk("t4_data", rsp_data, 64'h0);
        drain();

        // Reset with three operations in flight
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = '1;
            randomize_ops();
            tick();
        end
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_div_a", div_a, 64'h0);
        chk("t5_div_b", div_b, 64'h0);
        chk("t5_rsp_data", rsp_data, 64'h0);
        repeat (6) tick();
        req_valid = '1;
        randomize_ops();
        #1;
        chk("t5_ptr_restart", 64'(req_ready), 64'h1);
        tick();
        drain();

        // Sparse requests: pointer sits at 1, requester 3 then requester 1
        req_valid = 4'b1000;
        randomize_ops();
        #1;
        chk("t6_grant3", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("t6_grant1_wrap", 64'(req_ready), 64'h2);
        tick();
        drain();

        // Random traffic with intermittent backpressure
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom_range(15));
            rsp_ready = ($urandom_range(3) != 0);
            randomize_ops();
            tick();
        end
        drain();
        chk("scoreboard_empty", 64'(q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
